// File: rtl/avmm_sram_cmd_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : avmm_sram_cmd_buffer_if
// Brief    : Upstream Avalon-MM slave bundle plus downstream SRAM-controller
//            master bundle used by avmm_sram_cmd_buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface avmm_sram_cmd_buffer_if;
    logic [18:0] avs_address;
    logic [3:0]  avs_byteenable;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [18:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport slave (
        input  avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
        output avs_waitrequest, avs_readdata, avs_readdatavalid,
        output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        input  avm_readdata
    );

    modport master (
        output avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid,
        input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        output avm_readdata
    );
endinterface
`default_nettype wire

// File: rtl/avmm_sram_cmd_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : avmm_sram_cmd_buffer
// Brief    : Queues Avalon-MM commands and replays them to a fixed-latency SRAM
//            controller at a fixed issue cadence. Optional statistics counters
//            are enabled by defining SRAM_CMD_BUF_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module avmm_sram_cmd_buffer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 3,
    parameter int RD_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef SRAM_CMD_BUF_STATS_EN
    input  logic                  stat_clear,
    output logic [31:0]           stat_rd_cnt,
    output logic [31:0]           stat_wr_cnt,
    output logic [31:0]           stat_stall_cnt,
`endif
    avmm_sram_cmd_buffer_if.slave bus
);

    localparam int         c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int         c_GAP_W    = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP - 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(ISSUE_GAP - 2);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_GAP      = 2'd2;

    logic [55:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [1:0]         r_state;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_avm_read, r_avm_write;
    logic [18:0]        r_avm_address;
    logic [3:0]         r_avm_byteenable;
    logic [31:0]        r_avm_writedata;
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic               r_rd_valid;
    logic [31:0]        r_rd_data;

    logic        w_full, w_req, w_push, w_pop, w_avail, w_go_issue;
    logic [55:0] w_push_entry, w_head;

    assign w_full       = (r_count == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_req        = bus.avs_read | bus.avs_write;
    assign w_push       = w_req & ~w_full;
    // A write flag of 1 wins when read and write are both requested.
    assign w_push_entry = {bus.avs_write, bus.avs_address, bus.avs_byteenable, bus.avs_writedata};
    assign w_pop        = (r_state == c_ISSUE);
    assign w_avail      = (r_count != '0) | w_push;
    // Empty queue: forward the entry being pushed so an idle issuer starts next cycle.
    assign w_head       = (r_count != '0) ? r_mem[r_rd_ptr] : w_push_entry;
    assign w_go_issue   = w_avail & ((r_state == c_IDLE) |
                                     ((r_state == c_GAP) & (r_gap_cnt == '0)));

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= r_count + (c_PTR_W + 1)'(w_push) - (c_PTR_W + 1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: if (w_go_issue) r_state <= c_ISSUE;
                c_ISSUE: begin
                    r_state   <= c_GAP;
                    r_gap_cnt <= c_GAP_LOAD;
                end
                c_GAP: begin
                    if (r_gap_cnt == '0) r_state   <= w_avail ? c_ISSUE : c_IDLE;
                    else                 r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !w_go_issue) begin
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_address    <= '0;
            r_avm_byteenable <= '0;
            r_avm_writedata  <= '0;
        end else begin
            r_avm_write      <= w_head[55];
            r_avm_read       <= ~w_head[55];
            r_avm_address    <= w_head[54:36];
            r_avm_byteenable <= w_head[35:32];
            r_avm_writedata  <= w_head[31:0];
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_rd_pipe_one
            always_ff @(posedge clk) begin
                if (!reset_n) r_rd_pipe <= '0;
                else          r_rd_pipe <= r_avm_read;
            end
        end else begin : g_rd_pipe_multi
            always_ff @(posedge clk) begin
                if (!reset_n) r_rd_pipe <= '0;
                else          r_rd_pipe <= {r_rd_pipe[RD_LATENCY-2:0], r_avm_read};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= r_rd_pipe[RD_LATENCY-1];
            if (r_rd_pipe[RD_LATENCY-1]) r_rd_data <= bus.avm_readdata;
        end
    end

    assign bus.avs_waitrequest   = w_full;
    assign bus.avs_readdata      = r_rd_data;
    assign bus.avs_readdatavalid = r_rd_valid;
    assign bus.avm_address       = r_avm_address;
    assign bus.avm_byteenable    = r_avm_byteenable;
    assign bus.avm_read          = r_avm_read;
    assign bus.avm_write         = r_avm_write;
    assign bus.avm_writedata     = r_avm_writedata;

`ifdef SRAM_CMD_BUF_STATS_EN
    logic [31:0] r_stat_rd, r_stat_wr, r_stat_stall;

    always_ff @(posedge clk) begin
        if (!reset_n || stat_clear) begin
            r_stat_rd    <= '0;
            r_stat_wr    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (r_avm_read)       r_stat_rd    <= r_stat_rd + 32'd1;
            if (r_avm_write)      r_stat_wr    <= r_stat_wr + 32'd1;
            if (w_req && w_full)  r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_rd_cnt    = r_stat_rd;
    assign stat_wr_cnt    = r_stat_wr;
    assign stat_stall_cnt = r_stat_stall;
`endif

endmodule
`default_nettype wire
